// File: rtl/branch_resolve_unit_pkg.sv
// rtl/branch_resolve_unit_pkg.sv - shared types and defaults for the branch resolve unit
// Contents:
//   DEPTH_DEF, GHR_W_DEF, FLUSH_CYC_DEF : default parameter values
//   state_t                            : resolve FSM states
//   pred_entry_t                       : one in-flight prediction {taken, pc, target, ghr}
package branch_resolve_unit_pkg;

  localparam int DEPTH_DEF     = 4;
  localparam int GHR_W_DEF     = 9;
  localparam int FLUSH_CYC_DEF = 2;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_FLUSH = 1'b1
  } state_t;

  // Field order matches the packed queue word used by the top:
  // {taken, pc, target, ghr}, 65 + GHR_W bits.
  typedef struct packed {
    logic                 taken;
    logic [31:0]          pc;
    logic [31:0]          target;
    logic [GHR_W_DEF-1:0] ghr;
  } pred_entry_t;

  localparam int ENTRY_W_DEF = $bits(pred_entry_t);

endpackage

// File: rtl/branch_resolve_unit_pred_queue.sv
// rtl/branch_resolve_unit_pred_queue.sv - synchronous FIFO with synchronous clear
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   clear      : drop all entries (same effect as reset on pointers/count)
//   push       : write push_data at the tail (caller guarantees not full)
//   push_data  : entry to write
//   pop        : advance the head (caller guarantees not empty)
//   head_data  : oldest entry, undefined while empty
//   count      : number of valid entries, 0..DEPTH
module branch_resolve_unit_pred_queue #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 74
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clear,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head_data,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  // Storage is not reset; count/pointers define validity.
  always_ff @(posedge clk) begin
    if (push && !clear) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // DEPTH is a power of two, so pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign head_data = mem[rd_ptr];

endmodule

// File: rtl/branch_resolve_unit.sv
// rtl/branch_resolve_unit.sv - checks in-flight gshare predictions against execute outcomes
// Ports:
//   clk, rst                         : clock, synchronous active-high reset
//   pred_valid/pred_ready            : push of a predicted branch from fetch
//   pred_taken/pc/target/ghr         : prediction payload
//   res_valid/res_ready              : resolution of the oldest in-flight branch
//   res_taken/res_target             : actual outcome
//   mispredict, redirect_pc,
//   ghr_restore                      : registered recovery pulse and its data
//   upd_valid, upd_idx, upd_taken    : registered counter-training strobe and data
//   flush_busy                       : wrong-path flush in progress, fetch holds
module branch_resolve_unit
  import branch_resolve_unit_pkg::*;
#(
  parameter int DEPTH     = DEPTH_DEF,
  parameter int GHR_W     = GHR_W_DEF,
  parameter int FLUSH_CYC = FLUSH_CYC_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pred_valid,
  output logic             pred_ready,
  input  logic             pred_taken,
  input  logic [31:0]      pred_pc,
  input  logic [31:0]      pred_target,
  input  logic [GHR_W-1:0] pred_ghr,
  input  logic             res_valid,
  output logic             res_ready,
  input  logic             res_taken,
  input  logic [31:0]      res_target,
  output logic             mispredict,
  output logic [31:0]      redirect_pc,
  output logic [GHR_W-1:0] ghr_restore,
  output logic             upd_valid,
  output logic [GHR_W-1:0] upd_idx,
  output logic             upd_taken,
  output logic             flush_busy
);

  localparam int EW = 65 + GHR_W;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int BW = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  state_t           state;
  state_t           state_nx;
  logic [BW-1:0]    bub_cnt;
  logic             idle;

  logic [CW-1:0]    q_count;
  logic [EW-1:0]    push_data;
  logic [EW-1:0]    head;
  logic             push;
  logic             pop;
  logic             correct;
  logic             mis;

  logic             head_taken;
  logic [31:0]      head_pc;
  logic [31:0]      head_target;
  logic [GHR_W-1:0] head_ghr;

  assign push_data   = {pred_taken, pred_pc, pred_target, pred_ghr};
  assign head_taken  = head[EW-1];
  assign head_pc     = head[GHR_W+32 +: 32];
  assign head_target = head[GHR_W +: 32];
  assign head_ghr    = head[GHR_W-1:0];

  // Readiness depends only on registered state, never on res_*.
  assign pred_ready = (q_count < DEPTH_C) && idle;
  assign res_ready  = (q_count != '0) && idle;

  assign push = pred_valid && pred_ready;
  assign pop  = res_valid && res_ready;

  // Target only matters when the branch was actually taken.
  assign correct = (head_taken == res_taken) && (!res_taken || (head_target == res_target));
  assign mis     = pop && !correct;

  // A mispredict clears everything, including a push offered the same cycle.
  branch_resolve_unit_pred_queue #(
    .DEPTH (DEPTH),
    .WIDTH (EW)
  ) u_pred_queue (
    .clk       (clk),
    .rst       (rst),
    .clear     (mis),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .head_data (head),
    .count     (q_count)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      bub_cnt <= '0;
    end else begin
      state <= state_nx;
      if (state == ST_IDLE && mis) begin
        bub_cnt <= BW'(FLUSH_CYC - 1);
      end else if (state == ST_FLUSH && bub_cnt != '0) begin
        bub_cnt <= bub_cnt - BW'(1);
      end
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:  if (mis) state_nx = ST_FLUSH;
      ST_FLUSH: if (bub_cnt == '0) state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  always_comb begin
    idle       = (state == ST_IDLE);
    flush_busy = (state == ST_FLUSH);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      upd_valid   <= 1'b0;
      upd_idx     <= '0;
      upd_taken   <= 1'b0;
      mispredict  <= 1'b0;
      redirect_pc <= '0;
      ghr_restore <= '0;
    end else begin
      upd_valid  <= pop;
      mispredict <= mis;
      if (pop) begin
        upd_idx   <= head_pc[GHR_W-1:0] ^ head_ghr;
        upd_taken <= res_taken;
      end
      if (mis) begin
        redirect_pc <= res_taken ? res_target : head_pc + 32'd4;
        ghr_restore <= {head_ghr[GHR_W-2:0], res_taken};
      end
    end
  end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// tb/tb_branch_resolve_unit.sv - scoreboard bench for branch_resolve_unit
module tb_branch_resolve_unit;
  import branch_resolve_unit_pkg::*;

  localparam int DEPTH     = 4;
  localparam int GHR_W     = 9;
  localparam int FLUSH_CYC = 2;

  logic             clk;
  logic             rst;
  logic             pred_valid;
  logic             pred_ready;
  logic             pred_taken;
  logic [31:0]      pred_pc;
  logic [31:0]      pred_target;
  logic [GHR_W-1:0] pred_ghr;
  logic             res_valid;
  logic             res_ready;
  logic             res_taken;
  logic [31:0]      res_target;
  logic             mispredict;
  logic [31:0]      redirect_pc;
  logic [GHR_W-1:0] ghr_restore;
  logic             upd_valid;
  logic [GHR_W-1:0] upd_idx;
  logic             upd_taken;
  logic             flush_busy;

  branch_resolve_unit #(
    .DEPTH     (DEPTH),
    .GHR_W     (GHR_W),
    .FLUSH_CYC (FLUSH_CYC)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .pred_valid  (pred_valid),
    .pred_ready  (pred_ready),
    .pred_taken  (pred_taken),
    .pred_pc     (pred_pc),
    .pred_target (pred_target),
    .pred_ghr    (pred_ghr),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .res_taken   (res_taken),
    .res_target  (res_target),
    .mispredict  (mispredict),
    .redirect_pc (redirect_pc),
    .ghr_restore (ghr_restore),
    .upd_valid   (upd_valid),
    .upd_idx     (upd_idx),
    .upd_taken   (upd_taken),
    .flush_busy  (flush_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [GHR_W-1:0] idx;
    logic             taken;
    logic             mis;
    logic [31:0]      rpc;
    logic [GHR_W-1:0] grs;
  } exp_t;

  int n_cmp = 0;
  int n_bad = 0;

  pred_entry_t mq[$];
  exp_t        exp_q[$];
  int          flush_left = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, want);
    end
  endtask

  function automatic logic model_pred_ready();
    return (mq.size() < DEPTH) && (flush_left == 0);
  endfunction

  function automatic logic model_res_ready();
    return (mq.size() > 0) && (flush_left == 0);
  endfunction

  // Reference model: a branch queue plus a remaining-bubble count.
  logic        m_prdy, m_rrdy, m_push, m_pop, m_ok, m_mis;
  pred_entry_t m_head, m_new;
  exp_t        m_exp;

  always @(posedge clk) begin : model_step
    if (rst) begin
      mq.delete();
      flush_left = 0;
    end else begin
      m_prdy = model_pred_ready();
      m_rrdy = model_res_ready();
      if (flush_left > 0) flush_left = flush_left - 1;
      m_push = pred_valid && m_prdy;
      m_pop  = res_valid && m_rrdy;
      m_mis  = 1'b0;
      if (m_pop) begin
        m_head      = mq[0];
        m_ok        = (m_head.taken == res_taken) && (!res_taken || m_head.target == res_target);
        m_mis       = !m_ok;
        m_exp.idx   = m_head.pc[GHR_W-1:0] ^ m_head.ghr;
        m_exp.taken = res_taken;
        m_exp.mis   = m_mis;
        m_exp.rpc   = res_taken ? res_target : m_head.pc + 32'd4;
        m_exp.grs   = GHR_W'((int'(m_head.ghr) * 2 + int'(res_taken)) % (1 << GHR_W));
        exp_q.push_back(m_exp);
        if (m_mis) begin
          mq.delete();
          flush_left = FLUSH_CYC;
        end else begin
          void'(mq.pop_front());
        end
      end
      if (m_push && !m_mis) begin
        m_new.taken  = pred_taken;
        m_new.pc     = pred_pc;
        m_new.target = pred_target;
        m_new.ghr    = pred_ghr;
        mq.push_back(m_new);
      end
    end
  end

  exp_t mon_e;

  always @(posedge clk) begin : monitor
    #2;
    chk("pred_ready", 32'(pred_ready), 32'(model_pred_ready()));
    chk("res_ready", 32'(res_ready), 32'(model_res_ready()));
    chk("flush_busy", 32'(flush_busy), 32'(flush_left > 0));
    if (upd_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_upd: got upd_valid=1, expected no training pulse");
      end else begin
        mon_e = exp_q.pop_front();
        chk("upd_idx", 32'(upd_idx), 32'(mon_e.idx));
        chk("upd_taken", 32'(upd_taken), 32'(mon_e.taken));
        chk("mispredict", 32'(mispredict), 32'(mon_e.mis));
        if (mon_e.mis) begin
          chk("redirect_pc", redirect_pc, mon_e.rpc);
          chk("ghr_restore", 32'(ghr_restore), 32'(mon_e.grs));
        end
      end
    end else begin
      chk("mispredict_without_upd", 32'(mispredict), 32'd0);
    end
  end

  task automatic step(input logic r, input logic pv, input logic pt, input logic [31:0] pc,
                      input logic [31:0] tg, input logic [GHR_W-1:0] gh,
                      input logic rv, input logic rt, input logic [31:0] rtg);
    @(negedge clk);
    rst         = r;
    pred_valid  = pv;
    pred_taken  = pt;
    pred_pc     = pc;
    pred_target = tg;
    pred_ghr    = gh;
    res_valid   = rv;
    res_taken   = rt;
    res_target  = rtg;
    @(posedge clk);
    #3;
  endtask

  task automatic idle_step();
    step(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, '0, 1'b0, 1'b0, 32'd0);
  endtask

  task automatic push_one(input logic pt, input logic [31:0] pc, input logic [31:0] tg,
                          input logic [GHR_W-1:0] gh);
    step(1'b0, 1'b1, pt, pc, tg, gh, 1'b0, 1'b0, 32'd0);
  endtask

  task automatic resolve(input logic rt, input logic [31:0] rtg);
    step(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, '0, 1'b1, rt, rtg);
  endtask

  logic             r_rst, r_pv, r_pt, r_rv, r_rt;
  logic [31:0]      r_pc, r_tg, r_rtg;
  logic [GHR_W-1:0] r_gh;

  initial begin
    rst = 1'b1; pred_valid = 1'b0; pred_taken = 1'b0; pred_pc = '0; pred_target = '0;
    pred_ghr = '0; res_valid = 1'b0; res_taken = 1'b0; res_target = '0;

    step(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, '0, 1'b0, 1'b0, 32'd0);
    step(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, '0, 1'b0, 1'b0, 32'd0);
    chk("rst_mispredict", 32'(mispredict), 32'd0);
    chk("rst_upd_valid", 32'(upd_valid), 32'd0);
    chk("rst_flush_busy", 32'(flush_busy), 32'd0);
    chk("rst_redirect_pc", redirect_pc, 32'd0);
    chk("rst_ghr_restore", 32'(ghr_restore), 32'd0);
    chk("rst_upd_idx", 32'(upd_idx), 32'd0);
    chk("rst_upd_taken", 32'(upd_taken), 32'd0);
    chk("rst_pred_ready", 32'(pred_ready), 32'd1);
    chk("rst_res_ready", 32'(res_ready), 32'd0);

    // Fill to DEPTH, offer a fifth, then drain exactly four.
    for (int i = 0; i < 4; i++) push_one(1'b0, 32'h10 * i, 32'd0, GHR_W'(i));
    chk("full_pred_ready", 32'(pred_ready), 32'd0);
    push_one(1'b0, 32'h999, 32'd0, '0);
    chk("full_still_blocked", 32'(pred_ready), 32'd0);
    for (int i = 0; i < 4; i++) resolve(1'b0, 32'd0);
    chk("drain_last_idx", 32'(upd_idx), 32'h33);
    chk("drain_res_ready", 32'(res_ready), 32'd0);
    idle_step();

    // Correct taken prediction.
    push_one(1'b1, 32'h100, 32'h200, 9'h0A5);
    resolve(1'b1, 32'h200);
    chk("hit_upd_valid", 32'(upd_valid), 32'd1);
    chk("hit_upd_idx", 32'(upd_idx), 32'h1A5);
    chk("hit_upd_taken", 32'(upd_taken), 32'd1);
    chk("hit_mispredict", 32'(mispredict), 32'd0);

    // Direction mispredict with two younger wrong-path entries.
    push_one(1'b1, 32'h40, 32'h80, 9'h001);
    push_one(1'b0, 32'h50, 32'h0, 9'h002);
    push_one(1'b0, 32'h60, 32'h0, 9'h003);
    resolve(1'b0, 32'd0);
    chk("dir_mispredict", 32'(mispredict), 32'd1);
    chk("dir_redirect_pc", redirect_pc, 32'h44);
    chk("dir_ghr_restore", 32'(ghr_restore), 32'h002);
    chk("dir_flush_busy0", 32'(flush_busy), 32'd1);
    chk("dir_pred_ready0", 32'(pred_ready), 32'd0);
    idle_step();
    chk("dir_flush_busy1", 32'(flush_busy), 32'd1);
    chk("dir_pulse_once", 32'(mispredict), 32'd0);
    chk("dir_pred_ready1", 32'(pred_ready), 32'd0);
    idle_step();
    chk("dir_flush_done", 32'(flush_busy), 32'd0);
    chk("dir_queue_empty", 32'(res_ready), 32'd0);

    // Target mispredict.
    push_one(1'b1, 32'h500, 32'h300, 9'h000);
    resolve(1'b1, 32'h304);
    chk("tgt_mispredict", 32'(mispredict), 32'd1);
    chk("tgt_redirect_pc", redirect_pc, 32'h304);
    chk("tgt_ghr_restore", 32'(ghr_restore), 32'h001);
    idle_step();
    idle_step();

    // Full queue: simultaneous pop accepted, push rejected.
    for (int i = 0; i < 4; i++) push_one(1'b0, 32'h700 + 32'h4 * i, 32'd0, GHR_W'(i + 8));
    step(1'b0, 1'b1, 1'b0, 32'hBAD0, 32'd0, '0, 1'b1, 1'b0, 32'd0);
    chk("full_pop_upd", 32'(upd_valid), 32'd1);
    chk("full_pop_ready", 32'(pred_ready), 32'd1);
    push_one(1'b0, 32'h800, 32'd0, 9'h010);
    chk("refill_pred_ready", 32'(pred_ready), 32'd0);
    for (int i = 0; i < 4; i++) resolve(1'b0, 32'd0);
    chk("refill_last_idx", 32'(upd_idx), 32'h010);
    chk("refill_res_ready", 32'(res_ready), 32'd0);

    // Reset during the first flush cycle.
    push_one(1'b0, 32'h600, 32'd0, 9'h1FF);
    resolve(1'b1, 32'h1000);
    chk("rstflush_mispredict", 32'(mispredict), 32'd1);
    chk("rstflush_ghr_restore", 32'(ghr_restore), 32'h1FF);
    step(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, '0, 1'b0, 1'b0, 32'd0);
    chk("rstflush_busy", 32'(flush_busy), 32'd0);
    chk("rstflush_res_ready", 32'(res_ready), 32'd0);
    chk("rstflush_pred_ready", 32'(pred_ready), 32'd1);
    chk("rstflush_pulse", 32'(mispredict), 32'd0);
    idle_step();

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      r_rst = ($urandom_range(0, 299) == 0);
      r_pv  = 1'($urandom_range(0, 1));
      r_pt  = 1'($urandom_range(0, 1));
      r_pc  = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC : $urandom;
      r_tg  = $urandom;
      r_gh  = GHR_W'($urandom);
      r_rv  = ($urandom_range(0, 2) != 0);
      if (mq.size() > 0 && $urandom_range(0, 3) != 0) begin
        r_rt  = mq[0].taken;
        r_rtg = ($urandom_range(0, 3) != 0) ? mq[0].target : $urandom;
      end else begin
        r_rt  = 1'($urandom_range(0, 1));
        r_rtg = $urandom;
      end
      step(r_rst, r_pv, r_pt, r_pc, r_tg, r_gh, r_rv, r_rt, r_rtg);
    end

    idle_step();
    idle_step();
    idle_step();
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
- Execute-side counterpart of the fetch-stage gshare predictor.
- Holds every in-flight prediction (direction, target, GHR snapshot) in an ordered queue and checks each one against the resolved outcome from execute, oldest first.
- Returns training, GHR-restore and redirect information to fetch/predictor.
- On a mispredict, drives a flush-bubble sequence that discards all younger wrong-path entries.

Parameters:
- DEPTH, 4, in-flight prediction queue entries (power of 2, ≥2)
- GHR_W, 9, global history width; also the counter-table index width
- FLUSH_CYC, 2, bubble cycles held after a mispredict (≥1)

Ports:
- clk  in  1  clock
- rst  in  1  reset
- pred_valid  in  1  fetch issued a predicted branch this cycle
- pred_ready  out  1  queue can accept an entry
- pred_taken  in  1  predicted direction
- pred_pc  in  32  branch PC
- pred_target  in  32  predicted target (valid when pred_taken)
- pred_ghr  in  GHR_W  GHR value used to form the prediction index
- res_valid  in  1  execute resolves the oldest branch
- res_ready  out  1  an entry is available to resolve
- res_taken  in  1  actual direction
- res_target  in  32  actual target (valid when res_taken)
- mispredict  out  1  one-cycle pulse
- redirect_pc  out  32  correct next PC, valid with mispredict
- ghr_restore  out  GHR_W  corrected GHR, valid with mispredict
- upd_valid  out  1  counter-training strobe
- upd_idx  out  GHR_W  counter index to train
- upd_taken  out  1  training direction
- flush_busy  out  1  flush in progress; fetch must hold

Behaviour:
- Reset: rst is synchronous, active-high; clock is clk.
  - Queue empty, state IDLE.
  - mispredict, upd_valid, flush_busy = 0.
  - redirect_pc, ghr_restore, upd_idx, upd_taken = 0.
- Queue is a FIFO with count register 0..DEPTH; pointers wrap modulo DEPTH.
- pred_ready = (count<DEPTH) & state==IDLE. No combinational path from res_* to pred_ready; push-when-full is never accepted, even with a same-cycle pop.
- res_ready = (count>0) & state==IDLE.
- Push occurs on pred_valid&pred_ready. Pop occurs on res_valid&res_ready.
- Simultaneous push and pop: count unchanged, both pointers advance.
- Correct resolve: head.taken==res_taken AND (!res_taken OR head.target==res_target).
- Every pop, registered 1 cycle later:
  - upd_valid=1
  - upd_idx = head.pc[GHR_W-1:0] ^ head.ghr
  - upd_taken = res_taken
- Mispredicting pop, registered 1 cycle later:
  - mispredict=1
  - redirect_pc = res_taken ? res_target : head.pc+4 (32-bit wrap)
  - ghr_restore = {head.ghr[GHR_W-2:0], res_taken}
  - The whole queue is cleared the same edge (count←0, pointers←0). A push offered in the mispredict cycle is dropped; it is wrong-path.
- FSM:
  - IDLE→FLUSH on a mispredicting pop; bubble counter loads FLUSH_CYC-1.
  - FLUSH: flush_busy=1, no push/pop accepted, counter decrements; on counter==0 go to IDLE.
  - flush_busy is high for exactly FLUSH_CYC cycles, starting the cycle mispredict is high.
- Outputs mispredict and upd_valid are single-cycle pulses. redirect_pc, ghr_restore, upd_idx and upd_taken hold their last value otherwise.
- res_valid with count==0: ignored, no outputs.
- rst mid-flush: FSM→IDLE, queue empty, all pulses deasserted the next cycle.

Decomposition:
- Shared package: GHR_W default, FLUSH_CYC default, and an entry struct {taken, pc[31:0], target[31:0], ghr[GHR_W-1:0]} of width 65+GHR_W.
- One natural sub-module: pred_queue, a parameterised sync FIFO with a synchronous clear.

Test Plan:
- Reset, then 4 pushes with no resolves (DEPTH=4) → pred_ready=0 after the 4th; 5th pred_valid not accepted; count stays 4.
- Push pc=0x100, taken=1, target=0x200, ghr=0x0A5; resolve taken=1, target=0x200 → next cycle upd_valid=1, upd_idx=0x100^0x0A5=0x1A5, upd_taken=1, mispredict=0.
- Push pc=0x40, taken=1, ghr=0x001, plus 2 younger entries; resolve taken=0 → mispredict=1, redirect_pc=0x44, ghr_restore=0x002, queue empty; flush_busy high for exactly 2 cycles; pred_ready=0 during flush.
- Push taken=1, target=0x300; resolve taken=1, target=0x304 → mispredict=1, redirect_pc=0x304.
- Queue full with simultaneous pop and pred_valid → pop accepted, push rejected, count 3; next cycle push accepted, count 4.
- Assert rst during cycle 1 of flush → next cycle flush_busy=0, res_ready=0, pred_ready=1, mispredict=0.
